// File: rtl/data_mem_mmio.sv
// Data-side memory stage: word RAM plus LED, switch, cycle-counter and UART-TX registers.
// Reads are combinational; writes commit on the rising CLK edge.
module data_mem_mmio #(
  parameter int unsigned DMEM_WORDS = 128,
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned TXQ_DEPTH  = 8
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  output logic        UART_TX
);

  localparam int unsigned DmemAw = $clog2(DMEM_WORDS);
  localparam int unsigned PtrW   = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam int unsigned BaudW  = $clog2(BAUD_DIV);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
  localparam logic [3:0]       QDepth   = 4'(TXQ_DEPTH);

  localparam logic [29:0] DmemBase = 30'h200;
  localparam logic [29:0] LedWord  = 30'h300;
  localparam logic [29:0] SwWord   = 30'h301;
  localparam logic [29:0] TxDatWord = 30'h302;
  localparam logic [29:0] TxStaWord = 30'h303;
  localparam logic [29:0] CycWord  = 30'h304;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uartState_e;

  logic [29:0] wordAddr;
  logic [1:0]  unusedAddr;
  assign wordAddr   = Addr[31:2];
  assign unusedAddr = Addr[1:0];

  // DMEM base is a multiple of its size, so the low word-address bits index it directly.
  logic              dmemHit;
  logic [DmemAw-1:0] dmemIdx;
  assign dmemHit = (wordAddr >= DmemBase) && (wordAddr < 30'(32'h200 + DMEM_WORDS));
  assign dmemIdx = wordAddr[DmemAw-1:0];

  logic [31:0] dmem [DMEM_WORDS];
  logic [7:0]  txq  [TXQ_DEPTH];

  logic [15:0]     ledQ;
  logic [15:0]     swMetaQ, swSyncQ;
  logic [31:0]     cycQ;
  logic            ovfQ;
  logic [PtrW-1:0] wrPtrQ, rdPtrQ;
  logic [3:0]      countQ;

  uartState_e      stateQ;
  logic [BaudW-1:0] baudCntQ;
  logic [2:0]      bitIdxQ;
  logic [7:0]      shiftQ;
  logic            txQ;

  logic full, empty, busy, push, pop, doPush;
  assign full   = (countQ == QDepth);
  assign empty  = (countQ == 4'd0);
  assign busy   = (stateQ != StIdle);
  assign push   = MemWrite && (wordAddr == TxDatWord);
  assign pop    = (stateQ == StIdle) && !empty;
  assign doPush = push && (!full || pop);

  assign LED     = ledQ;
  assign UART_TX = txQ;

  always_comb begin
    ReadData = '0;
    if (dmemHit) begin
      ReadData = dmem[dmemIdx];
    end else begin
      case (wordAddr)
        LedWord:   ReadData = {16'b0, ledQ};
        SwWord:    ReadData = {16'b0, swSyncQ};
        TxStaWord: ReadData = {24'b0, countQ, ovfQ, busy, empty, full};
        CycWord:   ReadData = cycQ;
        default:   ReadData = '0;
      endcase
    end
  end

  // Storage arrays carry no reset; the FIFO is emptied through its pointers and count.
  always_ff @(posedge CLK) begin
    if (MemWrite && dmemHit) dmem[dmemIdx] <= WriteData;
    if (doPush) txq[wrPtrQ] <= WriteData[7:0];
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ledQ    <= '0;
      swMetaQ <= '0;
      swSyncQ <= '0;
      cycQ    <= '0;
      ovfQ    <= 1'b0;
      wrPtrQ  <= '0;
      rdPtrQ  <= '0;
      countQ  <= '0;
    end else begin
      swMetaQ <= SW;
      swSyncQ <= swMetaQ;
      if (MemWrite && (wordAddr == LedWord)) ledQ <= WriteData[15:0];
      cycQ <= (MemWrite && (wordAddr == CycWord)) ? '0 : cycQ + 32'd1;
      if (MemWrite && (wordAddr == TxStaWord)) ovfQ <= 1'b0;
      else if (push && full && !pop) ovfQ <= 1'b1;
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (pop) rdPtrQ <= rdPtrQ + 1'b1;
      countQ <= countQ + 4'(doPush) - 4'(pop);
    end
  end

  // 8N1 transmitter, LSB first; the head byte is latched on the IDLE->START edge.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ   <= StIdle;
      baudCntQ <= '0;
      bitIdxQ  <= '0;
      shiftQ   <= '0;
      txQ      <= 1'b1;
    end else begin
      case (stateQ)
        StIdle: begin
          if (!empty) begin
            stateQ   <= StStart;
            shiftQ   <= txq[rdPtrQ];
            baudCntQ <= '0;
            txQ      <= 1'b0;
          end
        end
        StStart: begin
          if (baudCntQ == BaudLast) begin
            stateQ   <= StData;
            baudCntQ <= '0;
            bitIdxQ  <= '0;
            txQ      <= shiftQ[0];
          end else begin
            baudCntQ <= baudCntQ + 1'b1;
          end
        end
        StData: begin
          if (baudCntQ == BaudLast) begin
            baudCntQ <= '0;
            if (bitIdxQ == 3'd7) begin
              stateQ <= StStop;
              txQ    <= 1'b1;
            end else begin
              bitIdxQ <= bitIdxQ + 1'b1;
              shiftQ  <= {1'b0, shiftQ[7:1]};
              txQ     <= shiftQ[1];
            end
          end else begin
            baudCntQ <= baudCntQ + 1'b1;
          end
        end
        StStop: begin
          if (baudCntQ == BaudLast) begin
            stateQ   <= StIdle;
            baudCntQ <= '0;
          end else begin
            baudCntQ <= baudCntQ + 1'b1;
          end
        end
        default: begin
          stateQ <= StIdle;
          txQ    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: DMEM, MMIO registers, cycle counter, UART FIFO and frames.
module tb_data_mem_mmio;

  localparam int Baud = 4;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [15:0] SW;
  logic [15:0] LED;
  logic        UART_TX;

  int total  = 0;
  int passed = 0;
  logic [7:0] rxq [$];

  always #5 CLK = ~CLK;

  data_mem_mmio #(
    .DMEM_WORDS(128),
    .BAUD_DIV  (Baud),
    .TXQ_DEPTH (8)
  ) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .SW       (SW),
    .LED      (LED),
    .UART_TX  (UART_TX)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr      = a;
    WriteData = d;
    MemWrite  = 1'b1;
    @(negedge CLK);
    MemWrite  = 1'b0;
  endtask

  task automatic chkRd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, {32'b0, ReadData}, {32'b0, exp});
  endtask

  // Serial receiver: samples mid-bit on falling CLK edges and queues each decoded byte.
  initial begin
    forever begin
      @(negedge CLK);
      if (Reset_n && UART_TX === 1'b0) begin
        logic [7:0] b;
        repeat (Baud / 2) @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
          repeat (Baud) @(negedge CLK);
          b[k] = UART_TX;
        end
        repeat (Baud) @(negedge CLK);
        rxq.push_back(b);
      end
    end
  end

  initial begin
    logic [63:0] obsv, expv;
    logic [7:0]  txByte;

    Reset_n = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0; SW = '0;
    repeat (3) @(negedge CLK);
    chk("rst_led", LED, 0);
    chk("rst_tx", UART_TX, 1);
    chkRd("rst_txsta", 32'hC0C, 32'h02);
    chkRd("rst_cyc", 32'hC10, 0);
    Reset_n = 1'b1;

    // Cycle counter
    repeat (10) @(negedge CLK);
    chkRd("cyc_10", 32'hC10, 10);
    wr(32'hC10, 32'h1234);
    chkRd("cyc_clr", 32'hC10, 0);
    @(negedge CLK);
    chkRd("cyc_inc", 32'hC10, 1);
    force dut.cycQ = 32'hFFFF_FFFF;
    #1 release dut.cycQ;
    chkRd("cyc_max", 32'hC10, 32'hFFFF_FFFF);
    @(negedge CLK);
    chkRd("cyc_wrap", 32'hC10, 0);

    // DMEM
    wr(32'h800, 32'h0);
    wr(32'h804, 32'hDEAD_BEEF);
    chkRd("dmem_804", 32'h804, 32'hDEAD_BEEF);
    chkRd("dmem_807", 32'h807, 32'hDEAD_BEEF);
    chkRd("dmem_800", 32'h800, 0);
    wr(32'h9FC, 32'hCAFE_F00D);
    chkRd("dmem_top", 32'h9FC, 32'hCAFE_F00D);
    wr(32'hA00, 32'h1);
    chkRd("past_dmem_rd", 32'hA00, 0);
    chkRd("past_dmem_alias", 32'h800, 0);

    // LED, SW, unmapped
    wr(32'hC00, 32'h1234_ABCD);
    chk("led_out", LED, 16'hABCD);
    chkRd("led_rd", 32'hC00, 32'h0000_ABCD);
    SW = 16'h00F0;
    @(negedge CLK);
    chkRd("sw_1edge", 32'hC04, 0);
    @(negedge CLK);
    chkRd("sw_2edge", 32'hC04, 32'h00F0);
    wr(32'hC04, 32'hFFFF_FFFF);
    chkRd("sw_ro", 32'hC04, 32'h00F0);
    chkRd("unmapped_rd", 32'hBFC, 0);
    wr(32'hBFC, 32'hFFFF_FFFF);
    chk("unmapped_led", LED, 16'hABCD);
    chkRd("unmapped_txsta", 32'hC0C, 32'h02);
    chkRd("unmapped_dmem", 32'h800, 0);

    // Single UART frame
    wr(32'hC08, 32'h0000_0155);
    chkRd("txsta_queued", 32'hC0C, 32'h10);
    @(negedge CLK);
    chkRd("txsta_busy", 32'hC0C, 32'h06);
    chkRd("txdat_rd", 32'hC08, 0);
    txByte = 8'h55;
    obsv = '0;
    expv = '0;
    for (int i = 0; i < 40; i++) begin
      obsv[i] = UART_TX;
      expv[i] = (i < 4) ? 1'b0 : (i < 36) ? txByte[(i - 4) / 4] : 1'b1;
      @(negedge CLK);
    end
    chk("frame_55", obsv, expv);
    chkRd("txsta_idle", 32'hC0C, 32'h02);

    // FIFO fill, overflow and drain
    rxq.delete();
    wr(32'hC08, 32'hA0);
    @(negedge CLK);
    for (int k = 0; k < 9; k++) wr(32'hC08, 32'hC0 + k);
    chkRd("fifo_full", 32'hC0C, 32'h8D);
    wr(32'hC0C, 32'h0);
    chkRd("ovf_clr", 32'hC0C, 32'h85);
    for (int n = 0; n < 800 && rxq.size() < 9; n++) @(negedge CLK);
    chk("rx_count", rxq.size(), 9);
    for (int k = 0; k < 9 && k < rxq.size(); k++)
      chk($sformatf("rx_byte%0d", k), rxq[k], (k == 0) ? 8'hA0 : 8'(8'hC0 + k - 1));
    repeat (5) @(negedge CLK);
    chkRd("txq_drained", 32'hC0C, 32'h02);

    // Reset mid-frame
    wr(32'hC08, 32'h00);
    wr(32'hC08, 32'h33);
    repeat (5) @(negedge CLK);
    chk("mid_data_low", UART_TX, 0);
    Reset_n = 1'b0;
    #1;
    chk("rst_tx_async", UART_TX, 1);
    @(negedge CLK);
    Reset_n = 1'b1;
    chkRd("rst_txsta_after", 32'hC0C, 32'h02);
    chkRd("dmem_keep", 32'h804, 32'hDEAD_BEEF);
    chk("rst_led_after", LED, 0);
    repeat (20) @(negedge CLK);
    chk("tx_quiet", UART_TX, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
